// File: rtl/rr_arbiter.sv
// Round-robin arbiter with burst hold: grant/select registered 1 cycle after request, o_valid combinational.
// Backpressure: i_ready=0 stalls the burst indefinitely; a dropped request abandons the grant.
module rr_arbiter #(
   parameter  int NUM_INPUTS = 6,
   parameter  int MAX_BURST  = 4,
   localparam int SEL_W      = $clog2(NUM_INPUTS),
   localparam int CNT_W      = $clog2(MAX_BURST + 1)
) (
   input  logic                  i_clk,
   input  logic                  i_rst,
   input  logic [NUM_INPUTS-1:0] i_req,
   input  logic                  i_last,
   input  logic                  i_ready,
   output logic [NUM_INPUTS-1:0] o_grant,
   output logic [SEL_W-1:0]      o_select,
   output logic                  o_valid
);

   typedef enum logic {IDLE, BUSY} state_e;

   state_e                  state_q, state_d;
   logic [NUM_INPUTS-1:0]   grant_q, grant_d;
   logic [SEL_W-1:0]        select_q, select_d;
   logic [SEL_W-1:0]        ptr_q, ptr_d;
   logic [CNT_W-1:0]        cnt_q, cnt_d;
   logic [SEL_W-1:0]        rel_ptr;
   logic                    req_held;
   logic                    beat;

   // First set request at or after start, wrapping past NUM_INPUTS-1.
   function automatic logic [SEL_W-1:0] pick(input logic [NUM_INPUTS-1:0] req,
                                             input logic [SEL_W-1:0]      start);
      logic [SEL_W:0]   idx;
      logic [SEL_W-1:0] win;
      logic             found;
      win   = start;
      found = 1'b0;
      for (int k = 0; k < NUM_INPUTS; k++) begin
         idx = {1'b0, start} + (SEL_W+1)'(k);
         if (idx >= (SEL_W+1)'(NUM_INPUTS)) idx = idx - (SEL_W+1)'(NUM_INPUTS);
         if (!found && req[idx[SEL_W-1:0]]) begin
            found = 1'b1;
            win   = idx[SEL_W-1:0];
         end
      end
      return win;
   endfunction

   assign req_held = i_req[select_q];
   assign beat     = (state_q == BUSY) && req_held && i_ready;
   assign rel_ptr  = (select_q == SEL_W'(NUM_INPUTS-1)) ? '0 : select_q + 1'b1;

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state_q  <= IDLE;
         grant_q  <= '0;
         select_q <= '0;
         ptr_q    <= '0;
         cnt_q    <= '0;
      end else begin
         state_q  <= state_d;
         grant_q  <= grant_d;
         select_q <= select_d;
         ptr_q    <= ptr_d;
         cnt_q    <= cnt_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      grant_d  = grant_q;
      select_d = select_q;
      ptr_d    = ptr_q;
      cnt_d    = cnt_q;
      case (state_q)
         IDLE: begin
            grant_d = '0;
            if (|i_req) begin
               state_d  = BUSY;
               select_d = pick(i_req, ptr_q);
               grant_d  = NUM_INPUTS'(1) << select_d;
               cnt_d    = '0;
            end
         end
         BUSY: begin
            if (!req_held) begin
               state_d = IDLE;
               grant_d = '0;
               cnt_d   = '0;
            end else if (beat && (i_last || cnt_q == CNT_W'(MAX_BURST-1))) begin
               // Release and re-arbitrate in the same cycle so back-to-back grants have no bubble.
               ptr_d = rel_ptr;
               cnt_d = '0;
               if (|i_req) begin
                  select_d = pick(i_req, rel_ptr);
                  grant_d  = NUM_INPUTS'(1) << select_d;
               end else begin
                  state_d = IDLE;
                  grant_d = '0;
               end
            end else if (beat) begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      o_grant  = grant_q;
      o_select = select_q;
      o_valid  = (state_q == BUSY) && req_held;
   end

endmodule

// File: tb/tb_rr_arbiter.sv
// Bench for rr_arbiter: directed scenarios plus randomized traffic against a transaction-level model.
module tb_rr_arbiter;
   localparam int N  = 6;
   localparam int MB = 4;
   localparam int SW = $clog2(N);

   logic          i_clk = 1'b0;
   logic          i_rst;
   logic [N-1:0]  i_req;
   logic          i_last;
   logic          i_ready;
   logic [N-1:0]  o_grant;
   logic [SW-1:0] o_select;
   logic          o_valid;

   int n_tests = 0;
   int n_fail  = 0;

   // Model: who holds the grant, how many beats it has moved, where the search starts next.
   bit m_busy;
   int m_sel, m_ptr, m_beats;

   rr_arbiter #(.NUM_INPUTS(N), .MAX_BURST(MB)) dut (
      .i_clk(i_clk), .i_rst(i_rst), .i_req(i_req), .i_last(i_last), .i_ready(i_ready),
      .o_grant(o_grant), .o_select(o_select), .o_valid(o_valid)
   );

   always #5 i_clk = ~i_clk;

   function automatic bit has(input logic [N-1:0] r, input int i);
      logic [N-1:0] t;
      t = r >> i;
      return t[0];
   endfunction

   function automatic int m_pick(input logic [N-1:0] r, input int from);
      for (int k = 0; k < N; k++)
         if (has(r, (from + k) % N)) return (from + k) % N;
      return from;
   endfunction

   function automatic logic [N+SW:0] exp_out();
      logic [N-1:0] g;
      g = m_busy ? (N'(1) << m_sel) : '0;
      return {g, SW'(m_sel), m_busy && has(i_req, m_sel)};
   endfunction

   task automatic m_reset();
      m_busy = 0; m_sel = 0; m_ptr = 0; m_beats = 0;
   endtask

   task automatic model_step();
      if (!m_busy) begin
         if (i_req != 0) begin
            m_sel = m_pick(i_req, m_ptr); m_busy = 1; m_beats = 0;
         end
      end else if (!has(i_req, m_sel)) begin
         m_busy = 0; m_beats = 0;
      end else if (i_ready) begin
         m_beats++;
         if (i_last || m_beats == MB) begin
            m_ptr   = (m_sel + 1) % N;
            m_beats = 0;
            if (i_req != 0) m_sel = m_pick(i_req, m_ptr);
            else            m_busy = 0;
         end
      end
   endtask

   // Advance one edge (model follows the inputs seen at the edge), then apply new inputs.
   task automatic drive(input logic [N-1:0] r, input logic l, input logic rd);
      @(posedge i_clk);
      if (!i_rst) model_step();
      #1; i_req = r; i_last = l; i_ready = rd;
      #3;
   endtask

   task automatic do_reset();
      i_req = '0; i_last = 0; i_ready = 0;
      i_rst = 1; m_reset();
      @(posedge i_clk); #1; i_rst = 0; #3;
   endtask

   task automatic test_reset();
      i_req = '0; i_last = 0; i_ready = 0; i_rst = 1; m_reset();
      #2;
      n_tests++;
      if ({o_grant, o_select, o_valid} !== '0) begin
         n_fail++; $display("FAIL reset_outputs: got %h, required 0", {o_grant, o_select, o_valid});
      end
      @(posedge i_clk); #1; i_rst = 0; #3;
      n_tests++;
      if ({o_grant, o_select, o_valid} !== exp_out()) begin
         n_fail++; $display("FAIL reset_idle: got %h, required %h", {o_grant, o_select, o_valid}, exp_out());
      end
   endtask

   task automatic test_single();
      do_reset();
      drive(6'b001000, 1, 1);
      drive(6'b001000, 1, 1);
      n_tests++;
      if (o_grant !== 6'b001000 || o_select !== 3'd3 || o_valid !== 1'b1) begin
         n_fail++; $display("FAIL single_grant: got g=%b s=%0d v=%b, required g=001000 s=3 v=1", o_grant, o_select, o_valid);
      end
      drive(6'b000000, 1, 1);
      drive(6'b000000, 1, 1);
      n_tests++;
      if (o_grant !== 6'b0 || o_valid !== 1'b0) begin
         n_fail++; $display("FAIL single_drop: got g=%b v=%b, required g=0 v=0", o_grant, o_valid);
      end
   endtask

   task automatic test_fairness();
      do_reset();
      drive(6'h3f, 1, 1);
      for (int k = 0; k < 7; k++) begin
         drive(6'h3f, 1, 1);
         n_tests++;
         if (o_select !== SW'(k % N) || o_valid !== 1'b1 || o_grant !== (N'(1) << (k % N))) begin
            n_fail++; $display("FAIL fairness[%0d]: got s=%0d v=%b g=%b, required s=%0d v=1", k, o_select, o_valid, o_grant, k % N);
         end
      end
   endtask

   task automatic test_forced_release();
      logic [SW-1:0] want;
      do_reset();
      drive(6'b010100, 0, 1);
      for (int k = 0; k < 10; k++) begin
         drive(6'b010100, 0, 1);
         want = ((k / MB) % 2 == 1) ? SW'(4) : SW'(2);
         n_tests++;
         if (o_select !== want || o_valid !== 1'b1) begin
            n_fail++; $display("FAIL forced_release[%0d]: got s=%0d v=%b, required s=%0d v=1", k, o_select, o_valid, want);
         end
      end
   endtask

   task automatic test_stall();
      do_reset();
      drive(6'b000110, 0, 1);
      drive(6'b000110, 0, 1);
      for (int k = 0; k < 5; k++) begin
         drive(6'b000110, 0, 0);
         n_tests++;
         if (o_select !== 3'd1 || o_valid !== 1'b1) begin
            n_fail++; $display("FAIL stall[%0d]: got s=%0d v=%b, required s=1 v=1", k, o_select, o_valid);
         end
      end
      drive(6'b000110, 0, 1);
      drive(6'b000110, 0, 1);
      drive(6'b000110, 0, 1);
      n_tests++;
      if (o_select !== 3'd1) begin
         n_fail++; $display("FAIL stall_last_beat: got s=%0d, required 1", o_select);
      end
      drive(6'b000110, 0, 1);
      n_tests++;
      if (o_select !== 3'd2 || o_grant !== 6'b000100) begin
         n_fail++; $display("FAIL stall_release: got s=%0d g=%b, required s=2 g=000100", o_select, o_grant);
      end
   endtask

   task automatic test_abandon();
      do_reset();
      drive(6'b010000, 1, 1);
      drive(6'b110000, 1, 1);
      drive(6'b100000, 0, 1);
      n_tests++;
      if (o_select !== 3'd5 || o_valid !== 1'b1) begin
         n_fail++; $display("FAIL abandon_grant5: got s=%0d v=%b, required s=5 v=1", o_select, o_valid);
      end
      drive(6'b000000, 0, 1);
      n_tests++;
      if (o_valid !== 1'b0 || o_grant !== 6'b100000) begin
         n_fail++; $display("FAIL abandon_valid: got v=%b g=%b, required v=0 g=100000", o_valid, o_grant);
      end
      drive(6'b100001, 0, 1);
      n_tests++;
      if (o_grant !== 6'b0) begin
         n_fail++; $display("FAIL abandon_idle: got g=%b, required 0", o_grant);
      end
      drive(6'b100001, 0, 1);
      n_tests++;
      if (o_select !== 3'd5 || o_grant !== 6'b100000) begin
         n_fail++; $display("FAIL abandon_ptr: got s=%0d g=%b, required s=5 g=100000", o_select, o_grant);
      end
   endtask

   task automatic test_async_reset();
      do_reset();
      drive(6'b001000, 0, 1);
      drive(6'b001000, 0, 1);
      #1; i_rst = 1; m_reset();
      #1;
      n_tests++;
      if ({o_grant, o_select, o_valid} !== '0) begin
         n_fail++; $display("FAIL async_reset: got %h, required 0", {o_grant, o_select, o_valid});
      end
      i_req = 6'h3f; i_last = 1; i_ready = 1;
      @(posedge i_clk); #2; i_rst = 0;
      drive(6'h3f, 1, 1);
      n_tests++;
      if (o_select !== 3'd0 || o_grant !== 6'b000001) begin
         n_fail++; $display("FAIL async_restart: got s=%0d g=%b, required s=0 g=000001", o_select, o_grant);
      end
   endtask

   task automatic test_random();
      logic [N-1:0] r;
      do_reset();
      for (int c = 0; c < 600; c++) begin
         r = N'($urandom);
         if ($urandom_range(0, 3) == 0) r = '0;
         // Usually keep the granted requester asserted so bursts actually run.
         if (m_busy && $urandom_range(0, 9) != 0) r = r | (N'(1) << m_sel);
         drive(r, ($urandom_range(0, 3) == 0), ($urandom_range(0, 9) < 7));
         n_tests++;
         if ({o_grant, o_select, o_valid} !== exp_out()) begin
            n_fail++; $display("FAIL random[%0d]: got %h, required %h", c, {o_grant, o_select, o_valid}, exp_out());
         end
      end
   endtask

   initial begin
      test_reset();
      test_single();
      test_fairness();
      test_forced_release();
      test_stall();
      test_abandon();
      test_async_reset();
      test_random();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
